// File: rtl/div_unit_rv32m.sv
// RV32M iterative divider: div/divu/rem/remu, one quotient bit per cycle.
// Ports: clk, reset (async low), start, funct3, src1/src2_value -> busy, done, result.
module div_unit_rv32m #(
  parameter int DATA_WIDTH = 32,
  parameter int END_IDX    = DATA_WIDTH - 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2:0]     funct3,
  input  logic [END_IDX:0] src1_value,
  input  logic [END_IDX:0] src2_value,
  output logic           busy,
  output logic           done,
  output logic [END_IDX:0] result
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [END_IDX:0] MIN_NEG =
    {1'b1, {END_IDX{1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [END_IDX:0] rem_q;
  logic [END_IDX:0] quot_q;
  logic [END_IDX:0] dvsr_q;
  logic [END_IDX:0] result_q;
  logic             rem_op;
  logic             neg_q;
  logic             neg_r;

  logic             is_uns;
  logic             is_rem;
  logic             a_neg;
  logic             b_neg;
  logic [END_IDX:0] a_mag;
  logic [END_IDX:0] b_mag;
  logic             div_zero;
  logic             ovf;

  logic [DATA_WIDTH:0] rem_sh;
  logic [DATA_WIDTH:0] trial;
  logic [END_IDX:0]    rem_nx;
  logic [END_IDX:0]    quot_nx;
  logic [END_IDX:0]    fin;

  logic unused_funct3;
  assign unused_funct3 = funct3[2];

  assign is_uns   = funct3[0];
  assign is_rem   = funct3[1];
  assign a_neg    = ~is_uns & src1_value[END_IDX];
  assign b_neg    = ~is_uns & src2_value[END_IDX];
  assign a_mag    = a_neg ? -src1_value : src1_value;
  assign b_mag    = b_neg ? -src2_value : src2_value;
  assign div_zero = (src2_value == '0);
  assign ovf      = ~is_uns
                  & (src1_value == MIN_NEG)
                  & (&src2_value);

  // rem < divisor always holds, so the trial fits in
  // DATA_WIDTH+1 bits and its MSB is a clean borrow.
  always_comb begin
    rem_sh  = {rem_q, quot_q[END_IDX]};
    trial   = rem_sh - {1'b0, dvsr_q};
    rem_nx  = trial[DATA_WIDTH] ? rem_sh[END_IDX:0]
                                : trial[END_IDX:0];
    quot_nx = {quot_q[END_IDX-1:0], ~trial[DATA_WIDTH]};
    fin     = quot_nx;
    if (rem_op)
      fin = neg_r ? -rem_nx : rem_nx;
    else
      fin = neg_q ? -quot_nx : quot_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      rem_op   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            rem_op <= is_rem;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            unique case (1'b1)
              div_zero: begin
                result_q <= is_rem ? src1_value : '1;
                state    <= S_DONE;
              end
              ovf: begin
                result_q <= is_rem ? '0 : MIN_NEG;
                state    <= S_DONE;
              end
              default: begin
                cnt    <= CNT_W'(DATA_WIDTH);
                rem_q  <= '0;
                quot_q <= a_mag;
                dvsr_q <= b_mag;
                state  <= S_CALC;
              end
            endcase
          end
        end
        S_CALC: begin
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          cnt    <= cnt - 1'b1;
          // Last iteration: commit the corrected value now
          if (cnt == CNT_W'(1)) begin
            result_q <= fin;
            state    <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_CALC);
  assign done   = (state == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit_rv32m.sv
// Self-checking bench for div_unit_rv32m.
// Directed plan cases plus random ops against an arithmetic model.
module tb_div_unit_rv32m;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] src1_value;
  logic [31:0] src2_value;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  div_unit_rv32m #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct3     (funct3),
    .src1_value (src1_value),
    .src2_value (src2_value),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0)
      return f3[1] ? a : 32'hFFFF_FFFF;
    if (f3[0]) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    return f3[1] ? r[31:0] : q[31:0];
  endfunction

  task automatic run_op(input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input bit poke);
    logic        special;
    logic        got;
    logic [31:0] prev;
    int n, busy_n, hold_bad, both;
    special = (b == 32'd0) ||
              (!f3[0] && a == 32'h8000_0000 &&
               b == 32'hFFFF_FFFF);
    @(negedge clk);
    prev       = result;
    start      = 1'b1;
    funct3     = f3;
    src1_value = a;
    src2_value = b;
    @(posedge clk);
    #1;
    start      = 1'b0;
    funct3     = 3'($urandom);
    src1_value = $urandom;
    src2_value = $urandom;
    n = 0; busy_n = 0; hold_bad = 0; both = 0;
    got = done;
    while (!got && n < 40) begin
      if (busy) busy_n++;
      if (result !== prev) hold_bad++;
      if (poke && n == 9) begin
        start      = 1'b1;
        funct3     = 3'b101;
        src1_value = $urandom;
        src2_value = $urandom | 32'd1;
      end
      if (poke && n == 10) start = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (busy && done) both++;
      got = done;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("done_edge", n, special ? 32'd0 : 32'd32);
    chk("busy_cycles", busy_n, special ? 32'd0 : 32'd32);
    chk("result_hold", hold_bad, 32'd0);
    chk("busy_and_done", both, 32'd0);
    chk("result", result, exp);
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int sel, saw;

    reset      = 1'b0;
    start      = 1'b0;
    funct3     = 3'b100;
    src1_value = '0;
    src2_value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b110, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 1'b0);
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 1'b0);
    run_op(3'b111, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1'b0);
    run_op(3'b111, 32'hFFFF_FFF9, 32'd2, 32'd1, 1'b0);
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b101, 32'd1000, 32'd10, 32'd100, 1'b1);

    for (int i = 0; i < 30; i++) begin
      f3  = {1'b1, 2'($urandom_range(0, 3))};
      a   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      else if (sel == 2) b = $urandom_range(1, 15);
      else b = $urandom;
      run_op(f3, a, b, model(f3, a, b), 1'b0);
    end

    run_op(3'b101, 32'd99, 32'd4, 32'd24, 1'b0);
    @(negedge clk);
    start      = 1'b1;
    funct3     = 3'b100;
    src1_value = 32'd1000;
    src2_value = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw++;
    end
    chk("abort_no_done", saw, 32'd0);

    run_op(3'b100, 32'hFFFF_FF9C, 32'd7,
           32'hFFFF_FFF2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
